// File: rtl/bw_mult_seq.sv
// -----------------------------------------------------------------------------
// bw_mult_seq
//   Multi-cycle Baugh-Wooley multiplier. ROWS_PER_CYCLE partial-product rows
//   are added into a 2*WIDTH accumulator on each ACCUM cycle, so a product
//   takes WIDTH/ROWS_PER_CYCLE cycles. A per-transaction mode bit selects
//   two's-complement (tc=1) or unsigned (tc=0) operands.
//
//   Handshakes: a transfer happens on a rising clk edge where valid && ready.
//   The producer holds valid (and data) until the transfer. in_ready is high
//   only in IDLE. out_valid is high only in DONE, and product stays stable
//   until the output transfer.
//
//   Optional build macro: BW_MULT_SEQ_RND_EN adds the prod_rnd output, which
//   is a rounded and saturated WIDTH-bit version of the product.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   operands valid
//   in_ready    out  block can accept operands (IDLE)
//   a, b        in   WIDTH-bit multiplicand / multiplier
//   tc          in   1 = two's complement operands, 0 = unsigned
//   out_valid   out  product valid (DONE)
//   out_ready   in   consumer accepts product
//   product     out  2*WIDTH-bit result
//   prod_rnd    out  rounded WIDTH-bit result (BW_MULT_SEQ_RND_EN only)
//   o_dbg_state out  current FSM state (0 IDLE, 1 ACCUM, 2 DONE)
// -----------------------------------------------------------------------------
module bw_mult_seq #(
  parameter int WIDTH          = 16,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 tc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
`ifdef BW_MULT_SEQ_RND_EN
  output logic [WIDTH-1:0]     prod_rnd,
`endif
  output logic [1:0]           o_dbg_state
);

  generate
    if (ROWS_PER_CYCLE < 1) begin : g_bad_rpc
      $error("bw_mult_seq: ROWS_PER_CYCLE must be >= 1");
    end else if (WIDTH < 2 || (WIDTH % ROWS_PER_CYCLE) != 0) begin : g_bad_width
      $error("bw_mult_seq: WIDTH must be >= 2 and divisible by ROWS_PER_CYCLE");
    end
  endgenerate

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Baugh-Wooley correction constant: 2^WIDTH + 2^(2*WIDTH-1).
  localparam logic [2*WIDTH-1:0] LOAD_TC =
    ((2*WIDTH)'(1) << WIDTH) | ((2*WIDTH)'(1) << (2*WIDTH-1));
  localparam logic [WIDTH-1:0] MASK_LO = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MASK_HI = ~MASK_LO;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_load;
  logic                 w_step;
  logic                 w_last;

  logic [WIDTH-1:0]     r_a_sh;   // multiplicand, shifted so row r's bit sits at [0]
  logic [WIDTH-1:0]     r_b;
  logic                 r_tc;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;    // index of the first row added this cycle
  logic [2*WIDTH-1:0]   r_product;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_row [ROWS_PER_CYCLE];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_load       = 1'b1;
          w_state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - ROWS_PER_CYCLE)) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign product     = r_product;
  assign o_dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Partial-product rows for this cycle
  // ---------------------------------------------------------------------------
  genvar gk;
  generate
    for (gk = 0; gk < ROWS_PER_CYCLE; gk++) begin : g_row
      logic [CNT_W-1:0] w_idx;
      logic [WIDTH-1:0] w_pp_raw;
      logic [WIDTH-1:0] w_pp;

      assign w_idx    = r_cnt + CNT_W'(gk);
      assign w_pp_raw = {WIDTH{r_a_sh[gk]}} & r_b;

      // In two's-complement mode, bits where exactly one index is the sign
      // position are inverted: the low bits of the top row, or the top bit
      // of every other row.
      always_comb begin
        w_pp = w_pp_raw;
        if (r_tc) begin
          if (w_idx == CNT_W'(WIDTH - 1)) begin
            w_pp = w_pp_raw ^ MASK_LO;
          end else begin
            w_pp = w_pp_raw ^ MASK_HI;
          end
        end
      end

      assign w_row[gk] = {{WIDTH{1'b0}}, w_pp} << w_idx;
    end
  endgenerate

  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
      w_acc_next = w_acc_next + w_row[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Optional rounding of the final accumulator
  // ---------------------------------------------------------------------------
`ifdef BW_MULT_SEQ_RND_EN
  localparam logic [2*WIDTH:0] RND_S = (2*WIDTH+1)'(1) << (WIDTH-2);
  localparam logic [2*WIDTH:0] RND_U = (2*WIDTH+1)'(1) << (WIDTH-1);

  logic [2*WIDTH:0]   w_rs;
  logic [2*WIDTH:0]   w_ru;
  logic [WIDTH+1:0]   w_rs_q;
  logic [WIDTH:0]     w_ru_q;
  logic [WIDTH-1:0]   w_rnd_next;
  logic [WIDTH-1:0]   r_prod_rnd;
  logic               w_rnd_unused;

  assign w_rs   = {w_acc_next[2*WIDTH-1], w_acc_next} + RND_S;
  assign w_ru   = {1'b0, w_acc_next} + RND_U;
  assign w_rs_q = w_rs[2*WIDTH:WIDTH-1];
  assign w_ru_q = w_ru[2*WIDTH:WIDTH];
  assign w_rnd_unused = ^{w_rs[WIDTH-2:0], w_ru[WIDTH-1:0]};

  always_comb begin
    w_rnd_next = '0;
    if (r_tc) begin
      // Fits in WIDTH signed bits only if the three top bits agree.
      if (w_rs_q[WIDTH+1:WIDTH-1] == 3'b000 || w_rs_q[WIDTH+1:WIDTH-1] == 3'b111) begin
        w_rnd_next = w_rs_q[WIDTH-1:0];
      end else if (w_rs_q[WIDTH+1]) begin
        w_rnd_next = MASK_HI;
      end else begin
        w_rnd_next = MASK_LO;
      end
    end else begin
      w_rnd_next = w_ru_q[WIDTH] ? {WIDTH{1'b1}} : w_ru_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_rnd <= '0;
    end else if (w_step && w_last) begin
      r_prod_rnd <= w_rnd_next;
    end
  end

  assign prod_rnd = r_prod_rnd;
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b       <= '0;
      r_tc      <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_load) begin
      r_a_sh <= a;
      r_b    <= b;
      r_tc   <= tc;
      r_acc  <= tc ? LOAD_TC : '0;
      r_cnt  <= '0;
    end else if (w_step) begin
      r_a_sh <= r_a_sh >> ROWS_PER_CYCLE;
      r_acc  <= w_acc_next;
      r_cnt  <= r_cnt + CNT_W'(ROWS_PER_CYCLE);
      if (w_last) begin
        r_product <= w_acc_next;
      end
    end
  end

endmodule
